pe_packet_injector: RTL and testbench

- PE-side transmit network interface: the sending counterpart to the PE's receive path.
- Accepts payload words with a destination address from local PE logic and buffers them in a FIFO.
- Wraps each word into the NoC packet format {dest, src, data} and drives it to the router input port with a valid/ready handshake.
- Keeps a sent-packet count and a sticky overflow flag for debug.

---
 rtl/pe_packet_injector.sv | 144 ++++++++++++++
 tb/tb_pe_packet_injector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_packet_injector.sv
`default_nettype none
// ============================================================================
// Module   : pe_packet_injector
// Brief    : PE transmit NI: buffers {dest, src, payload} packets in a FIFO and
//            drives them to the router through a valid/ready holding slot.
// Revision : 1.0 - initial release
// ============================================================================
module pe_packet_injector #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int LOCAL_ADDR = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_wr_en,
    input  logic [DATA_WIDTH-1:0]            i_payload,
    input  logic [ADDR_WIDTH-1:0]            i_dest,
    output logic                             o_full,
    output logic                             o_empty,
    input  logic                             i_ready_from_router,
    output logic                             o_valid_to_router,
    output logic [DATA_WIDTH+2*ADDR_WIDTH-1:0] o_data_to_router,
    output logic [CNT_WIDTH-1:0]             o_tx_count,
    output logic                             o_overflow
);

    localparam int c_pkt_w = DATA_WIDTH + 2 * ADDR_WIDTH;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_occ_w = c_ptr_w + 1;
    localparam logic [ADDR_WIDTH-1:0] c_local = ADDR_WIDTH'(LOCAL_ADDR);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_pkt_w-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_occ_w-1:0]   r_occ;
    logic [c_pkt_w-1:0]   r_slot;
    logic [CNT_WIDTH-1:0] r_tx_count;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_handshake;
    logic [c_pkt_w-1:0]   w_pkt;

    assign w_full  = (r_occ == c_occ_w'(FIFO_DEPTH));
    assign w_empty = (r_occ == '0);
    // Full is judged on the registered occupancy, so a same-cycle pop never rescues a write.
    assign w_push  = i_wr_en && !w_full;
    assign w_pkt   = {i_dest, c_local, i_payload};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_occ_w'(1);
                2'b01:   r_occ <= r_occ - c_occ_w'(1);
                default: r_occ <= r_occ;
            endcase
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_slot     <= '0;
            r_tx_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_slot <= r_mem[r_rd_ptr];
            end
            if (w_handshake) begin
                r_tx_count <= r_tx_count + CNT_WIDTH'(1);
            end
        end
    end

    // The slot refills whenever it is idle or being emptied by a handshake this edge.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (i_ready_from_router) begin
                    w_handshake = 1'b1;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_full            = w_full;
    assign o_empty           = w_empty;
    assign o_valid_to_router = (r_state == S_SEND);
    assign o_data_to_router  = r_slot;
    assign o_tx_count        = r_tx_count;
    assign o_overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pe_packet_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_packet_injector
// Brief    : Scoreboard bench for pe_packet_injector with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_packet_injector;

    localparam int c_dw    = 16;
    localparam int c_aw    = 2;
    localparam int c_local = 1;
    localparam int c_depth = 4;
    localparam int c_cw    = 4;
    localparam int c_pw    = c_dw + 2 * c_aw;

    logic             clk;
    logic             rst;
    logic             i_wr_en;
    logic [c_dw-1:0]  i_payload;
    logic [c_aw-1:0]  i_dest;
    logic             o_full;
    logic             o_empty;
    logic             i_ready_from_router;
    logic             o_valid_to_router;
    logic [c_pw-1:0]  o_data_to_router;
    logic [c_cw-1:0]  o_tx_count;
    logic             o_overflow;

    pe_packet_injector #(
        .DATA_WIDTH (c_dw),
        .ADDR_WIDTH (c_aw),
        .LOCAL_ADDR (c_local),
        .FIFO_DEPTH (c_depth),
        .CNT_WIDTH  (c_cw)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_wr_en             (i_wr_en),
        .i_payload           (i_payload),
        .i_dest              (i_dest),
        .o_full              (o_full),
        .o_empty             (o_empty),
        .i_ready_from_router (i_ready_from_router),
        .o_valid_to_router   (o_valid_to_router),
        .o_data_to_router    (o_data_to_router),
        .o_tx_count          (o_tx_count),
        .o_overflow          (o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: buffered packets, the presented packet, and debug state.
    logic [c_pw-1:0] m_fifo[$];
    logic [c_pw-1:0] exp_q[$];
    bit              m_slot_valid;
    logic [c_pw-1:0] m_slot_pkt;
    int              m_sent;
    bit              m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [c_pw-1:0] mk_pkt(input logic [c_aw-1:0] d, input logic [c_dw-1:0] p);
        logic [c_aw-1:0] src;
        src = c_aw'(c_local);
        return {d, src, p};
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        exp_q.delete();
        m_slot_valid = 0;
        m_slot_pkt   = '0;
        m_sent       = 0;
        m_ovf        = 0;
    endtask

    task automatic model_step(input bit wr, input logic [c_pw-1:0] pkt, input bit rdy);
        int  old_size;
        bit  xfer;
        old_size = m_fifo.size();
        xfer     = m_slot_valid && rdy;
        if (xfer) m_sent++;
        if (!m_slot_valid || xfer) begin
            if (old_size > 0) begin
                m_slot_pkt   = m_fifo.pop_front();
                m_slot_valid = 1;
            end else begin
                m_slot_valid = 0;
            end
        end
        if (wr) begin
            if (old_size < c_depth) begin
                m_fifo.push_back(pkt);
                exp_q.push_back(pkt);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic tick(input bit wr, input logic [c_dw-1:0] pay, input logic [c_aw-1:0] dst, input bit rdy);
        i_wr_en             = wr;
        i_payload           = pay;
        i_dest              = dst;
        i_ready_from_router = rdy;
        @(posedge clk);
        model_step(wr, mk_pkt(dst, pay), rdy);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_valid_to_router), 32'd0);
        chk({tag, "_empty"}, 32'(o_empty), 32'd1);
        chk({tag, "_full"},  32'(o_full), 32'd0);
        chk({tag, "_data"},  32'(o_data_to_router), 32'd0);
        chk({tag, "_cnt"},   32'(o_tx_count), 32'd0);
        chk({tag, "_ovf"},   32'(o_overflow), 32'd0);
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is observable before any edge.
    task automatic async_reset();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        model_clear();
        i_wr_en = 1'b1;
        i_ready_from_router = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        i_wr_en = 1'b0;
        i_ready_from_router = 1'b0;
        rst = 1'b1;
    endtask

    // Monitor: checks status against the model and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("valid", 32'(o_valid_to_router), 32'(m_slot_valid));
            chk("full",  32'(o_full), 32'(m_fifo.size() == c_depth));
            chk("empty", 32'(o_empty), 32'(m_fifo.size() == 0));
            chk("count", 32'(o_tx_count), 32'(m_sent % (1 << c_cw)));
            chk("ovf",   32'(o_overflow), 32'(m_ovf));
            if (m_slot_valid) chk("slot_data", 32'(o_data_to_router), 32'(m_slot_pkt));
            if (o_valid_to_router === 1'b1 && i_ready_from_router === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pkt", 32'(o_data_to_router), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_data", 32'(o_data_to_router), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        i_wr_en = 0; i_payload = '0; i_dest = '0; i_ready_from_router = 0; rst = 1'b1;
        #1;
        async_reset();

        // First packet: latency and format.
        tick(1, 16'hA5A5, 2'd2, 1);
        tick(0, 16'h0, 2'd0, 1);
        chk("first_valid", 32'(o_valid_to_router), 32'd1);
        chk("first_data", 32'(o_data_to_router), 32'h9A5A5);
        tick(0, 16'h0, 2'd0, 1);
        chk("first_cnt", 32'(o_tx_count), 32'd1);
        chk("first_idle", 32'(o_valid_to_router), 32'd0);

        // Backpressure.
        async_reset();
        tick(1, 16'h0001, 2'd3, 0);
        for (int i = 0; i < 5; i++) tick(0, 16'h0, 2'd0, 0);
        chk("bp_hold_data", 32'(o_data_to_router), 32'h D0001);
        tick(0, 16'h0, 2'd0, 1);
        tick(0, 16'h0, 2'd0, 0);
        chk("bp_cnt", 32'(o_tx_count), 32'd1);
        chk("bp_idle", 32'(o_valid_to_router), 32'd0);

        // Fill and overflow.
        async_reset();
        for (int i = 1; i <= 6; i++) tick(1, 16'(i), 2'(i), 0);
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_ovf", 32'(o_overflow), 32'd1);
        for (int i = 0; i < 6; i++) tick(0, 16'h0, 2'd0, 1);
        chk("drain_cnt", 32'(o_tx_count), 32'd5);
        chk("drain_empty", 32'(o_empty), 32'd1);
        chk("drain_ovf", 32'(o_overflow), 32'd1);

        // Streaming.
        async_reset();
        for (int i = 0; i < 20; i++) tick(1, 16'(16'h1000 + i), 2'(i % 4), 1);
        tick(0, 16'h0, 2'd0, 1);
        tick(0, 16'h0, 2'd0, 1);
        chk("stream_cnt", 32'(o_tx_count), 32'(20 % 16));

        // Reset mid-operation.
        async_reset();
        for (int i = 0; i < 3; i++) tick(1, 16'(16'h0BAD + i), 2'd1, 0);
        tick(0, 16'h0, 2'd0, 0);
        async_reset();
        for (int i = 0; i < 5; i++) tick(0, 16'h0, 2'd0, 1);
        chk("mid_rst_no_stale", 32'(o_valid_to_router), 32'd0);

        // Counter wrap.
        async_reset();
        for (int i = 0; i < 17; i++) tick(1, 16'(i * 7), 2'(i), 1);
        for (int i = 0; i < 3; i++) tick(0, 16'h0, 2'd0, 1);
        chk("wrap_cnt", 32'(o_tx_count), 32'd1);

        // Random traffic.
        async_reset();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 2) != 0, 16'($urandom), 2'($urandom), $urandom_range(0, 3) == 0 ? 1'b0 : 1'b1);
        end
        for (int i = 0; i < 8; i++) tick(0, 16'h0, 2'd0, 1);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
